// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the LEGv8 hazard controller: FSM states, forwarding selects, XZR index.
// Definitions only; no latency, no backpressure.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HOLD      = 2'd1,
        HOLD_PEND = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [4:0] ZR_IDX = 5'd31;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Forwarding select for one EX-stage source operand; EX/MEM result beats MEM/WB.
// Latency: combinational. Backpressure: none, evaluated every cycle.
module fwd_unit #(
    parameter logic [4:0] ZR_IDX = hazard_ctrl_pkg::ZR_IDX
) (
    input  logic [4:0] src,
    input  logic [4:0] mem_write_reg,
    input  logic       mem_regwrite,
    input  logic [4:0] wb_write_reg,
    input  logic       wb_regwrite,
    output logic [1:0] sel
);
    import hazard_ctrl_pkg::*;

    always_comb begin
        sel = FWD_RF;
        if (mem_regwrite && (mem_write_reg != ZR_IDX) && (mem_write_reg == src)) begin
            sel = FWD_MEM;
        end else if (wb_regwrite && (wb_write_reg != ZR_IDX) && (wb_write_reg == src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// LEGv8 5-stage hazard controller: load-use stall, branch flush, memory-wait freeze, forwarding, event counters.
// Latency: all controls combinational; counters update on the following edge. Backpressure: mem_busy freezes every stage.
module hazard_ctrl #(
    parameter int         CNT_W  = 32,
    parameter logic [4:0] ZR_IDX = hazard_ctrl_pkg::ZR_IDX
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_uses_rm,
    input  logic [4:0]       ex_rn,
    input  logic [4:0]       ex_rm,
    input  logic [4:0]       ex_write_reg,
    input  logic             ex_memread,
    input  logic [4:0]       mem_write_reg,
    input  logic             mem_regwrite,
    input  logic             mem_branch_taken,
    input  logic [4:0]       wb_write_reg,
    input  logic             wb_regwrite,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             idex_bubble,
    output logic             flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);
    import hazard_ctrl_pkg::*;

    state_t     state_q, state_d;
    logic       load_use;
    logic       do_flush;
    logic       do_bubble;
    logic [1:0] fa_raw, fb_raw;

    assign load_use = ex_memread && (ex_write_reg != ZR_IDX) &&
                      ((ex_write_reg == id_rn) || (id_uses_rm && (ex_write_reg == id_rm)));

    // A taken branch seen while frozen is remembered in HOLD_PEND and flushed on the exit cycle.
    always_comb begin
        state_d   = state_q;
        do_flush  = 1'b0;
        do_bubble = 1'b0;
        if (mem_busy) begin
            if (mem_branch_taken || (state_q == HOLD_PEND)) begin
                state_d = HOLD_PEND;
            end else begin
                state_d = HOLD;
            end
        end else begin
            state_d = RUN;
            if (mem_branch_taken || (state_q == HOLD_PEND)) begin
                do_flush = 1'b1;
            end else if (load_use) begin
                do_bubble = 1'b1;
            end
        end
    end

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        exmem_write = 1'b1;
        idex_bubble = 1'b0;
        flush       = 1'b0;
        if (rst_n) begin
            if (mem_busy) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_write  = 1'b0;
                exmem_write = 1'b0;
            end else if (do_bubble) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
            flush = do_flush;
        end
    end

    fwd_unit #(.ZR_IDX(ZR_IDX)) u_fwd_a (
        .src          (ex_rn),
        .mem_write_reg(mem_write_reg),
        .mem_regwrite (mem_regwrite),
        .wb_write_reg (wb_write_reg),
        .wb_regwrite  (wb_regwrite),
        .sel          (fa_raw)
    );

    fwd_unit #(.ZR_IDX(ZR_IDX)) u_fwd_b (
        .src          (ex_rm),
        .mem_write_reg(mem_write_reg),
        .mem_regwrite (mem_regwrite),
        .wb_write_reg (wb_write_reg),
        .wb_regwrite  (wb_regwrite),
        .sel          (fb_raw)
    );

    assign fwd_a = rst_n ? fa_raw : FWD_RF;
    assign fwd_b = rst_n ? fb_raw : FWD_RF;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state_q <= state_d;
            if (do_bubble) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (do_flush) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl; expected responses are queued by the driver and checked by a monitor.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       rst_n;
        logic [4:0] id_rn;
        logic [4:0] id_rm;
        logic       id_uses_rm;
        logic [4:0] ex_rn;
        logic [4:0] ex_rm;
        logic [4:0] ex_write_reg;
        logic       ex_memread;
        logic [4:0] mem_write_reg;
        logic       mem_regwrite;
        logic       mem_branch_taken;
        logic [4:0] wb_write_reg;
        logic       wb_regwrite;
        logic       mem_busy;
    } in_t;

    typedef struct packed {
        logic        pc;
        logic        ifid;
        logic        idex;
        logic        exmem;
        logic        bub;
        logic        fl;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    logic        clock;
    in_t         drv;
    logic        pc_write, ifid_write, idex_write, exmem_write, idex_bubble, flush;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_count, flush_count;

    exp_t  exp_q[$];
    string name_q[$];
    int    tests;
    int    fails;

    hazard_ctrl #(.CNT_W(32), .ZR_IDX(5'd31)) dut (
        .clock           (clock),
        .rst_n           (drv.rst_n),
        .id_rn           (drv.id_rn),
        .id_rm           (drv.id_rm),
        .id_uses_rm      (drv.id_uses_rm),
        .ex_rn           (drv.ex_rn),
        .ex_rm           (drv.ex_rm),
        .ex_write_reg    (drv.ex_write_reg),
        .ex_memread      (drv.ex_memread),
        .mem_write_reg   (drv.mem_write_reg),
        .mem_regwrite    (drv.mem_regwrite),
        .mem_branch_taken(drv.mem_branch_taken),
        .wb_write_reg    (drv.wb_write_reg),
        .wb_regwrite     (drv.wb_regwrite),
        .mem_busy        (drv.mem_busy),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .idex_write      (idex_write),
        .exmem_write     (exmem_write),
        .idex_bubble     (idex_bubble),
        .flush           (flush),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic in_t base();
        in_t v;
        v.rst_n            = 1'b1;
        v.id_rn            = 5'd1;
        v.id_rm            = 5'd3;
        v.id_uses_rm       = 1'b1;
        v.ex_rn            = 5'd10;
        v.ex_rm            = 5'd11;
        v.ex_write_reg     = 5'd20;
        v.ex_memread       = 1'b0;
        v.mem_write_reg    = 5'd21;
        v.mem_regwrite     = 1'b0;
        v.mem_branch_taken = 1'b0;
        v.wb_write_reg     = 5'd22;
        v.wb_regwrite      = 1'b0;
        v.mem_busy         = 1'b0;
        return v;
    endfunction

    function automatic exp_t nrm(input int s, input int f);
        exp_t e;
        e.pc    = 1'b1;
        e.ifid  = 1'b1;
        e.idex  = 1'b1;
        e.exmem = 1'b1;
        e.bub   = 1'b0;
        e.fl    = 1'b0;
        e.fa    = 2'b00;
        e.fb    = 2'b00;
        e.sc    = 32'(s);
        e.fc    = 32'(f);
        return e;
    endfunction

    function automatic exp_t stl(input int s, input int f);
        exp_t e;
        e      = nrm(s, f);
        e.pc   = 1'b0;
        e.ifid = 1'b0;
        e.bub  = 1'b1;
        return e;
    endfunction

    function automatic exp_t frz(input int s, input int f);
        exp_t e;
        e       = nrm(s, f);
        e.pc    = 1'b0;
        e.ifid  = 1'b0;
        e.idex  = 1'b0;
        e.exmem = 1'b0;
        return e;
    endfunction

    task automatic step(input string nm, input in_t v, input exp_t e);
        @(posedge clock);
        #1;
        drv = v;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  a;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = {pc_write, ifid_write, idex_write, exmem_write, idex_bubble, flush,
                 fwd_a, fwd_b, stall_count, flush_count};
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL %s: got pc/ifid/idex/exmem=%b%b%b%b bub=%b fl=%b fa=%b fb=%b sc=%0d fc=%0d, expected %b%b%b%b bub=%b fl=%b fa=%b fb=%b sc=%0d fc=%0d",
                         n, a.pc, a.ifid, a.idex, a.exmem, a.bub, a.fl, a.fa, a.fb, a.sc, a.fc,
                         e.pc, e.ifid, e.idex, e.exmem, e.bub, e.fl, e.fa, e.fb, e.sc, e.fc);
            end
        end
    end

    initial begin
        in_t  v;
        exp_t e;
        tests = 0;
        fails = 0;
        drv = base();
        drv.rst_n = 1'b0;

        // In reset: hazard and forwarding inputs active, outputs must stay at reset values.
        v = base(); v.rst_n = 1'b0; v.ex_memread = 1'b1; v.ex_write_reg = 5'd1;
        v.mem_regwrite = 1'b1; v.mem_write_reg = 5'd10;
        step("reset_outputs", v, nrm(0, 0));

        v = base();
        step("normal", v, nrm(0, 0));

        v = base(); v.ex_memread = 1'b1; v.ex_write_reg = 5'd2; v.id_rn = 5'd2;
        step("loaduse_rn", v, stl(0, 0));
        v = base();
        step("after_bubble", v, nrm(1, 0));

        v = base(); v.ex_memread = 1'b1; v.ex_write_reg = 5'd3;
        step("loaduse_rm", v, stl(1, 0));
        v.id_uses_rm = 1'b0;
        step("rm_unused", v, nrm(2, 0));

        v = base(); v.ex_memread = 1'b1; v.ex_write_reg = 5'd31; v.id_rn = 5'd31;
        step("xzr_no_stall", v, nrm(2, 0));

        v = base(); v.mem_regwrite = 1'b1; v.mem_write_reg = 5'd31; v.ex_rn = 5'd31;
        step("xzr_no_fwd_mem", v, nrm(2, 0));

        v = base(); v.mem_regwrite = 1'b1; v.mem_write_reg = 5'd5;
        v.wb_regwrite = 1'b1; v.wb_write_reg = 5'd5; v.ex_rn = 5'd5; v.ex_rm = 5'd5;
        e = nrm(2, 0); e.fa = 2'b10; e.fb = 2'b10;
        step("fwd_mem_wins", v, e);
        v.mem_regwrite = 1'b0;
        e = nrm(2, 0); e.fa = 2'b01; e.fb = 2'b01;
        step("fwd_wb_only", v, e);

        v = base(); v.mem_regwrite = 1'b1; v.mem_write_reg = 5'd10;
        v.wb_regwrite = 1'b1; v.wb_write_reg = 5'd11;
        e = nrm(2, 0); e.fa = 2'b10; e.fb = 2'b01;
        step("fwd_split", v, e);

        v = base(); v.wb_regwrite = 1'b1; v.wb_write_reg = 5'd31; v.ex_rn = 5'd31;
        step("xzr_no_fwd_wb", v, nrm(2, 0));

        v = base(); v.mem_branch_taken = 1'b1; v.ex_memread = 1'b1; v.ex_write_reg = 5'd2; v.id_rn = 5'd2;
        e = nrm(2, 0); e.fl = 1'b1;
        step("flush_beats_stall", v, e);
        v = base();
        step("after_flush", v, nrm(2, 1));

        // Freeze with a branch arriving in the second busy cycle.
        v = base(); v.mem_busy = 1'b1; v.mem_regwrite = 1'b1; v.mem_write_reg = 5'd10;
        e = frz(2, 1); e.fa = 2'b10;
        step("freeze1_fwd", v, e);
        v = base(); v.mem_busy = 1'b1; v.mem_branch_taken = 1'b1;
        step("freeze2_branch", v, frz(2, 1));
        v = base(); v.mem_busy = 1'b1; v.ex_memread = 1'b1; v.ex_write_reg = 5'd1;
        step("freeze3_loaduse", v, frz(2, 1));
        v = base();
        e = nrm(2, 1); e.fl = 1'b1;
        step("pending_flush", v, e);
        step("after_pending", v, nrm(2, 2));

        v = base(); v.mem_busy = 1'b1;
        step("hold_plain", v, frz(2, 2));
        v = base();
        step("hold_exit_noflush", v, nrm(2, 2));

        // Async reset while in HOLD_PEND discards the pending branch.
        v = base(); v.mem_busy = 1'b1; v.mem_branch_taken = 1'b1;
        step("enter_pend", v, frz(2, 2));
        v.mem_branch_taken = 1'b0;
        step("in_pend", v, frz(2, 2));
        v = base(); v.rst_n = 1'b0; v.mem_busy = 1'b1;
        v.wb_regwrite = 1'b1; v.wb_write_reg = 5'd10;
        step("reset_mid_pend", v, nrm(0, 0));
        v = base();
        step("release_noflush", v, nrm(0, 0));
        step("run_after_reset", v, nrm(0, 0));

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clock);
        #1;
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d checks left unconsumed, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage LEGv8 CPU.
- Consumes the state held in the ID/EX, EX/MEM and MEM/WB pipeline registers and the ID-stage instruction fields.
- Drives back into the pipeline: PC/IF-ID write enables, ID/EX bubble insertion, flushes after a taken branch, a whole-pipeline freeze during memory wait, and EX-stage forwarding selects.
- Also keeps stall and flush event counters for performance debug.

Parameters:
- CNT_W, 32, width of the stall and flush event counters.
- ZR_IDX, 31, register index of XZR; this register never creates a hazard or a forward.

Ports:
- clock  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rn  in  5  ID-stage instruction[9:5].
- id_rm  in  5  ID-stage instruction[20:16], or [4:0] for STUR/CBZ (selected upstream).
- id_uses_rm  in  1  the ID instruction reads id_rm.
- ex_rn  in  5  source register 1 index held in ID/EX.
- ex_rm  in  5  source register 2 index held in ID/EX.
- ex_write_reg  in  5  destination register held in ID/EX.
- ex_memread  in  1  Memread held in ID/EX.
- mem_write_reg  in  5  destination register held in EX/MEM.
- mem_regwrite  in  1  RegWrite held in EX/MEM.
- mem_branch_taken  in  1  Branch AND zero flag in the MEM stage.
- wb_write_reg  in  5  destination register held in MEM/WB.
- wb_regwrite  in  1  RegWrite held in MEM/WB.
- mem_busy  in  1  data memory not ready; the pipeline must freeze.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID load enable.
- idex_write  out  1  ID/EX load enable.
- exmem_write  out  1  EX/MEM and MEM/WB load enable.
- idex_bubble  out  1  zero all control fields when loading ID/EX.
- flush  out  1  clear IF/ID, ID/EX and EX/MEM control fields.
- fwd_a  out  2  ALU operand A select: 00 register file, 01 MEM/WB, 10 EX/MEM.
- fwd_b  out  2  ALU operand B select, same encoding as fwd_a.
- stall_count  out  CNT_W  number of load-use bubbles inserted.
- flush_count  out  CNT_W  number of branch flushes applied.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to RUN; counters clear to 0.
  - Outputs while in reset: pc_write, ifid_write, idex_write and exmem_write are 1; idex_bubble and flush are 0; fwd_a and fwd_b are 00.
- FSM states:
  - RUN to HOLD when mem_busy=1 and mem_branch_taken=0.
  - RUN to HOLD_PEND when mem_busy=1 and mem_branch_taken=1.
  - HOLD to HOLD_PEND when mem_branch_taken=1 and mem_busy=1.
  - HOLD to RUN when mem_busy=0.
  - HOLD_PEND to RUN when mem_busy=0.
- HOLD and HOLD_PEND:
  - All four write enables are 0; bubble and flush are 0.
  - The branch-pending flag lives in the state, so no branch is lost while frozen.
- Flush, combinational outputs:
  - flush=1 in RUN with mem_branch_taken=1 and mem_busy=0.
  - flush=1 in HOLD_PEND on the exit cycle (mem_busy=0).
  - The flush lasts exactly one cycle. All write enables are 1 that cycle, so the PC takes the branch target.
- Load-use hazard (in RUN, no flush, mem_busy=0):
  - Condition: ex_memread=1, ex_write_reg!=ZR_IDX, and either ex_write_reg==id_rn or (id_uses_rm=1 and ex_write_reg==id_rm).
  - Response: pc_write=0, ifid_write=0, idex_bubble=1, other enables 1.
  - The bubble clears ex_memread, so exactly one stall cycle results with no re-detection.
- Priority: reset > mem_busy freeze > flush > load-use stall > normal.
- Forwarding, combinational, evaluated every cycle including freeze:
  - fwd_a=10 if mem_regwrite=1, mem_write_reg!=ZR_IDX and mem_write_reg==ex_rn.
  - Else fwd_a=01 if wb_regwrite=1, wb_write_reg!=ZR_IDX and wb_write_reg==ex_rn.
  - Else fwd_a=00.
  - fwd_b uses the same rule with ex_rm. EX/MEM always wins over MEM/WB.
- Counters:
  - stall_count increments on the rising edge after each cycle with idex_bubble=1.
  - flush_count increments on the rising edge after each cycle with flush=1.
  - Both wrap modulo 2^CNT_W and never saturate.
- Reset mid-freeze: a pending branch is discarded and the FSM returns to RUN.

Decomposition:
- Shared package: FSM state encoding (RUN=0, HOLD=1, HOLD_PEND=2), forwarding select constants (FWD_RF, FWD_WB, FWD_MEM) and ZR_IDX.
- One natural sub-module: fwd_unit, the purely combinational forwarding logic, instantiated twice (operands A and B) or once with dual outputs.
- The FSM and the counters stay in hazard_ctrl.

Test Plan:
- Load-use: ID/EX is LDUR X2 (ex_memread=1, ex_write_reg=2); ID is ADD with id_rn=2. Required: one cycle of pc_write=0, ifid_write=0, idex_bubble=1, then normal operation; stall_count=1.
- XZR: ex_write_reg=31, ex_memread=1, id_rn=31. Required: no stall. Separately, mem_write_reg=31 with mem_regwrite=1 and ex_rn=31 gives fwd_a=00.
- Forward priority: mem_write_reg=5 and wb_write_reg=5, both regwrite=1, ex_rn=5 and ex_rm=5. Required: fwd_a=10, fwd_b=10. With mem_regwrite=0: fwd_a=01.
- Branch during freeze: mem_busy=1 for 3 cycles with mem_branch_taken pulsed in cycle 2. Required: all enables 0 for the 3 cycles, then flush=1 for exactly one cycle after mem_busy drops; flush_count=1.
- Flush beats stall: mem_branch_taken=1 while the load-use condition holds. Required: flush=1, idex_bubble=0, stall_count unchanged.
- Async reset: assert rst_n=0 mid-clock while in HOLD_PEND. Required: immediate RUN state, counters 0, no flush after release.
